power_rail_scanner: RTL and testbench

- Parametrised successor to the fixed 7-way rail mux rotator.
- Steps an external analog mux through NUM_CH rail channels and waits a programmable settling time before sampling the shared comparator line (status_in).
- Filters each channel's result, latches faults and drives the master kill switch.
- Sits between the GPIO header (mux selects, comparator, kill line) and the status LEDs / host logic.

---
 rtl/power_rail_scanner.sv | 140 ++++++++++++++
 tb/tb_power_rail_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/power_rail_scanner.sv
// Rotating rail monitor: steps an analog mux over NUM_CH rails, filters each sample,
// latches faults and drives the master kill switch. Define PWR_SCAN_LED_EN to add the led port.
module power_rail_scanner #(
  parameter int unsigned       NUM_CH        = 7,
  parameter int unsigned       SEL_W         = 3,
  parameter int unsigned       SETTLE_CYCLES = 512,
  parameter int unsigned       FILT_LEN      = 4,
  parameter logic [NUM_CH-1:0] KILL_MASK     = {NUM_CH{1'b1}}
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              kill_req,
  input  logic              fault_clear,
  input  logic              status_in,
  output logic [SEL_W-1:0]  mux_sel,
  output logic              kill_sw,
  output logic [NUM_CH-1:0] ch_ok,
  output logic [NUM_CH-1:0] fault_latched,
  output logic              scan_done,
  output logic              fault_irq
`ifdef PWR_SCAN_LED_EN
  ,
  output logic [NUM_CH-1:0] led
`endif
);

  localparam int unsigned      CntW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0]  SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LastCh      = SEL_W'(NUM_CH - 1);
  localparam logic [3:0]       FiltLast    = 4'(FILT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StAdvance} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         settle_cnt_q;
  logic [NUM_CH-1:0][3:0]  filt_cnt_q;
  logic [NUM_CH-1:0][3:0]  filt_cnt_d;
  logic [NUM_CH-1:0]       ch_ok_d;
  logic [NUM_CH-1:0]       new_bad;
  logic [NUM_CH-1:0]       fault_d;
  logic                    irq_pend_q;

  // Filter update for the selected channel; only active in the sample cycle.
  always_comb begin
    ch_ok_d    = ch_ok;
    filt_cnt_d = filt_cnt_q;
    new_bad    = '0;
    if (state_q == StSample) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (mux_sel == SEL_W'(i)) begin
          if (status_in == ch_ok[i]) begin
            filt_cnt_d[i] = '0;
          end else if (filt_cnt_q[i] == FiltLast) begin
            ch_ok_d[i]    = status_in;
            filt_cnt_d[i] = '0;
            new_bad[i]    = ~status_in;
          end else begin
            filt_cnt_d[i] = filt_cnt_q[i] + 4'd1;
          end
        end
      end
    end
    // A flip to bad in the same cycle overrides the clear.
    fault_d = (fault_latched & ~(fault_clear ? ch_ok : '0)) | new_bad;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= StIdle;
      settle_cnt_q  <= '0;
      filt_cnt_q    <= '0;
      mux_sel       <= '0;
      kill_sw       <= 1'b0;
      ch_ok         <= '1;
      fault_latched <= '0;
      scan_done     <= 1'b0;
      fault_irq     <= 1'b0;
      irq_pend_q    <= 1'b0;
    end else begin
      kill_sw       <= enable & ~kill_req & ~|(fault_latched & KILL_MASK);
      ch_ok         <= ch_ok_d;
      filt_cnt_q    <= filt_cnt_d;
      fault_latched <= fault_d;
      irq_pend_q    <= |(new_bad & ~fault_latched);
      fault_irq     <= irq_pend_q;
      scan_done     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          mux_sel      <= '0;
          settle_cnt_q <= '0;
          if (enable) state_q <= StSettle;
        end
        StSettle: begin
          if (settle_cnt_q == SettleLast) begin
            settle_cnt_q <= '0;
            state_q      <= StSample;
          end else begin
            settle_cnt_q <= settle_cnt_q + CntW'(1);
          end
        end
        StSample: state_q <= StAdvance;
        StAdvance: begin
          if (mux_sel == LastCh) begin
            mux_sel   <= '0;
            scan_done <= 1'b1;
          end else begin
            mux_sel <= mux_sel + SEL_W'(1);
          end
          // The channel in flight always completes; idle parks the mux on channel 0.
          if (!enable) begin
            mux_sel <= '0;
            state_q <= StIdle;
          end else begin
            state_q <= StSettle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PWR_SCAN_LED_EN
  logic       blink_q;
  logic [2:0] blink_cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else if (scan_done) begin
      blink_cnt_q <= blink_cnt_q + 3'd1;
      if (blink_cnt_q == 3'd7) blink_q <= ~blink_q;
    end
  end

  assign led = (ch_ok & ~fault_latched) | (fault_latched & {NUM_CH{blink_q}});
`endif

endmodule

// File: tb/tb_power_rail_scanner.sv
// Directed plus randomized bench for power_rail_scanner against a cycle-level scan model.
module tb_power_rail_scanner;
  localparam int N = 3;
  localparam int S = 4;
  localparam int F = 2;
  localparam logic [2:0] MASK = 3'b011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       kill_req = 1'b0;
  logic       fault_clear = 1'b0;
  logic       status_in = 1'b1;
  logic [1:0] mux_sel;
  logic       kill_sw;
  logic [2:0] ch_ok;
  logic [2:0] fault_latched;
  logic       scan_done;
  logic       fault_irq;
`ifdef PWR_SCAN_LED_EN
  logic [2:0] led;
`endif

  power_rail_scanner #(
    .NUM_CH(N), .SEL_W(2), .SETTLE_CYCLES(S), .FILT_LEN(F), .KILL_MASK(MASK)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .kill_req(kill_req),
    .fault_clear(fault_clear), .status_in(status_in), .mux_sel(mux_sel), .kill_sw(kill_sw),
    .ch_ok(ch_ok), .fault_latched(fault_latched), .scan_done(scan_done), .fault_irq(fault_irq)
`ifdef PWR_SCAN_LED_EN
    , .led(led)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the scan, per-channel filter and fault state.
  bit       m_active;
  int       m_phase;
  int       m_ch;
  bit [2:0] m_ok;
  bit [2:0] m_flt;
  bit [2:0] m_flt_prev;
  int       m_cnt[3];
  bit       m_kill;
  bit       m_done;
  bit       m_irq;
  bit [2:0] rail = 3'b111;
  int       done_cnt;
  int       irq_cnt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit [2:0] old_flt;
    bit [2:0] old_ok;
    bit [2:0] bad;
    if (reset) begin
      m_active = 0; m_phase = 0; m_ch = 0; m_ok = 3'b111; m_flt = 0; m_flt_prev = 0;
      m_kill = 0; m_done = 0; m_irq = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    old_flt = m_flt;
    old_ok  = m_ok;
    bad     = 0;
    m_kill  = enable && !kill_req && ((old_flt & MASK) == 0);
    m_irq   = |(old_flt & ~m_flt_prev);
    m_flt_prev = old_flt;
    m_done  = 0;
    if (!m_active) begin
      if (enable) begin
        m_active = 1;
        m_phase  = 0;
      end
    end else if (m_phase == S) begin
      if (status_in == m_ok[m_ch]) begin
        m_cnt[m_ch] = 0;
      end else begin
        m_cnt[m_ch]++;
        if (m_cnt[m_ch] == F) begin
          m_ok[m_ch]  = status_in;
          m_cnt[m_ch] = 0;
          if (!status_in) bad[m_ch] = 1'b1;
        end
      end
      m_phase++;
    end else if (m_phase == S + 1) begin
      m_done  = (m_ch == N - 1);
      m_ch    = (m_ch + 1) % N;
      m_phase = 0;
      if (!enable) begin
        m_active = 0;
        m_ch     = 0;
      end
    end else begin
      m_phase++;
    end
    m_flt = (old_flt & ~(fault_clear ? old_ok : 3'b000)) | bad;
  endtask

  task automatic step();
    status_in = rail[m_ch];
    @(posedge clk);
    model_edge();
    #1;
    check("mux_sel", 8'(mux_sel), 8'(m_ch));
    check("kill_sw", 8'(kill_sw), 8'(m_kill));
    check("ch_ok", 8'(ch_ok), 8'(m_ok));
    check("fault_latched", 8'(fault_latched), 8'(m_flt));
    check("scan_done", 8'(scan_done), 8'(m_done));
    check("fault_irq", 8'(fault_irq), 8'(m_irq));
    done_cnt += int'(scan_done);
    irq_cnt  += int'(fault_irq);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_phase(input int ch, input int ph);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_active && m_ch == ch && m_phase == ph) hit = 1;
      else step();
    end
    check("wait_phase_bound", 8'(hit), 8'd1);
  endtask

  initial begin
    // Reset state
    run(3);
    check("rst_mux", 8'(mux_sel), 8'd0);
    check("rst_kill", 8'(kill_sw), 8'd0);
    check("rst_ok", 8'(ch_ok), 8'h07);
    check("rst_flt", 8'(fault_latched), 8'd0);
    reset = 0;
    step();

    // Power-up: kill_sw one cycle after enable, three scans in 54 cycles
    enable = 1;
    step();
    check("pwrup_kill", 8'(kill_sw), 8'd1);
    done_cnt = 0;
    run(54);
    check("scan_done_count", 8'(done_cnt), 8'd3);

    // Unmasked fault on channel 2 latches but keeps power
    irq_cnt = 0;
    rail[2] = 0;
    run(36);
    check("unmasked_ok", 8'(ch_ok), 8'h03);
    check("unmasked_flt", 8'(fault_latched), 8'h04);
    check("unmasked_kill", 8'(kill_sw), 8'd1);
    check("unmasked_irq", 8'(irq_cnt), 8'd1);

    // Single bad sample on channel 1 is filtered out
    rail[1] = 0;
    run(18);
    rail[1] = 1;
    run(18);
    check("glitch_ok", 8'(ch_ok), 8'h03);
    check("glitch_flt", 8'(fault_latched), 8'h04);

    // Two bad samples on channel 1 trip the masked fault
    irq_cnt = 0;
    rail[1] = 0;
    run(36);
    check("fault_ok", 8'(ch_ok), 8'h01);
    check("fault_flt", 8'(fault_latched), 8'h06);
    check("fault_kill", 8'(kill_sw), 8'd0);
    check("fault_irq_count", 8'(irq_cnt), 8'd1);

    // Clear while still bad has no effect
    fault_clear = 1;
    step();
    fault_clear = 0;
    step();
    check("clear_bad_flt", 8'(fault_latched), 8'h06);

    // Recover, then clear restores power one cycle later
    rail = 3'b111;
    run(36);
    check("recover_ok", 8'(ch_ok), 8'h07);
    fault_clear = 1;
    step();
    fault_clear = 0;
    check("clear_flt", 8'(fault_latched), 8'h00);
    step();
    check("clear_kill", 8'(kill_sw), 8'd1);

    // Randomized rails, clears and kill requests
    repeat (30) begin
      rail = 3'($urandom) | 3'($urandom);
      repeat (18) begin
        fault_clear = ($urandom_range(0, 9) == 0);
        kill_req    = ($urandom_range(0, 19) == 0);
        step();
      end
    end
    fault_clear = 0;
    kill_req    = 0;

    // kill_req mid-settle drops power while scanning continues
    rail = 3'b111;
    run(36);
    fault_clear = 1;
    step();
    fault_clear = 0;
    step();
    check("pre_kill", 8'(kill_sw), 8'd1);
    wait_phase(0, 1);
    kill_req = 1;
    step();
    check("kill_req_kill", 8'(kill_sw), 8'd0);
    kill_req = 0;
    run(2);
    check("kill_req_release", 8'(kill_sw), 8'd1);

    // enable drop mid-settle on channel 1 finishes the channel then idles
    wait_phase(1, 1);
    enable = 0;
    run(3);
    check("disable_finishing", 8'(mux_sel), 8'd1);
    run(10);
    check("disable_idle_mux", 8'(mux_sel), 8'd0);
    check("disable_kill", 8'(kill_sw), 8'd0);

    // Reset mid-scan with a fault latched
    enable = 1;
    rail   = 3'b110;
    run(40);
    check("pre_reset_flt", 8'(fault_latched), 8'h01);
    reset = 1;
    step();
    check("mid_rst_mux", 8'(mux_sel), 8'd0);
    check("mid_rst_kill", 8'(kill_sw), 8'd0);
    check("mid_rst_ok", 8'(ch_ok), 8'h07);
    check("mid_rst_flt", 8'(fault_latched), 8'd0);
    check("mid_rst_done", 8'(scan_done), 8'd0);
    check("mid_rst_irq", 8'(fault_irq), 8'd0);
    reset = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
